// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory: size encodings, FSM states,
// lane-mask helper and wait-counter width.
package dm_pkg;

   localparam int CNT_W  = 4;
   localparam int NLANES = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   // Byte lanes touched by an access; an illegal size touches nothing.
   function automatic logic [NLANES-1:0] lane_mask(input size_e size, input logic [1:0] a_lo);
      logic [NLANES-1:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << a_lo;
         SZ_HALF: m = a_lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// Request/response bus between the MEM stage and the byte-lane data memory.
interface data_memory_bytelane_if #(
   parameter int WIDTH      = 32,
   parameter int TEST_WIDTH = 16
);
   logic                  Req;
   logic                  WE;
   logic [1:0]            Size;
   logic                  Unsigned;
   logic [WIDTH-1:0]      A;
   logic [WIDTH-1:0]      WD;
   logic [WIDTH-1:0]      RD;
   logic                  Ready;
   logic                  Busy;
   logic                  Misaligned;
   logic                  Out_Of_Range;
   logic [TEST_WIDTH-1:0] Test_Value;

   modport master (
      output Req, WE, Size, Unsigned, A, WD,
      input  RD, Ready, Busy, Misaligned, Out_Of_Range, Test_Value
   );

   modport slave (
      input  Req, WE, Size, Unsigned, A, WD,
      output RD, Ready, Busy, Misaligned, Out_Of_Range, Test_Value
   );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store-side mask/data replication and load-side
// lane extraction with sign or zero extension.
module dm_lane_align
   import dm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  size_e              i_size,
   input  logic [1:0]         i_a_lo,
   input  logic               i_unsigned,
   input  logic [WIDTH-1:0]   i_wd,
   input  logic [WIDTH-1:0]   i_rd_word,
   output logic [NLANES-1:0]  o_wmask,
   output logic [WIDTH-1:0]   o_wdata,
   output logic [WIDTH-1:0]   o_rdata
);

   logic [WIDTH-1:0] w_sh;

   // Halfword lanes are only valid for even a_lo, so one byte-granular shift serves both sizes.
   assign w_sh    = i_rd_word >> {i_a_lo, 3'b000};
   assign o_wmask = lane_mask(i_size, i_a_lo);

   always_comb begin
      o_wdata = '0;
      o_rdata = '0;
      case (i_size)
         SZ_BYTE: begin
            o_wdata = {4{i_wd[7:0]}};
            o_rdata = i_unsigned ? {{(WIDTH-8){1'b0}}, w_sh[7:0]}
                                 : {{(WIDTH-8){w_sh[7]}}, w_sh[7:0]};
         end
         SZ_HALF: begin
            o_wdata = {2{i_wd[15:0]}};
            o_rdata = i_unsigned ? {{(WIDTH-16){1'b0}}, w_sh[15:0]}
                                 : {{(WIDTH-16){w_sh[15]}}, w_sh[15:0]};
         end
         SZ_WORD: begin
            o_wdata = i_wd;
            o_rdata = i_rd_word;
         end
         default: begin
            o_wdata = '0;
            o_rdata = '0;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory with wait states, Req/Ready handshake, fault
// detection and a debug mirror of one RAM word.
module data_memory_bytelane
   import dm_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0,
   parameter int TEST_WIDTH  = 16,
   parameter int TEST_ADDR   = 0
) (
   input  logic                    CLK,
   input  logic                    RST,
   data_memory_bytelane_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_wd;
   logic               r_we;
   size_e              r_size;
   logic               r_uns;

   logic [WIDTH-1:0]   r_ram [DEPTH];

   logic               w_ready;
   logic               w_mis;
   logic               w_oor;
   logic               w_fault;
   logic               w_commit;
   logic [IDX_W-1:0]   w_idx;
   logic [NLANES-1:0]  w_wmask;
   logic [WIDTH-1:0]   w_wdata;
   logic [WIDTH-1:0]   w_ld_data;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.Req) begin
               if (WAIT_STATES > 0) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
               end else begin
                  w_state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (r_cnt == '0) w_state_nxt = RESP;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request fields are pure data; a reset drops the transaction through the state register alone.
   always_ff @(posedge CLK) begin
      if (r_state == IDLE && bus.Req) begin
         r_a    <= bus.A;
         r_wd   <= bus.WD;
         r_we   <= bus.WE;
         r_size <= size_e'(bus.Size);
         r_uns  <= bus.Unsigned;
      end
   end

   assign w_ready  = (r_state == RESP);
   assign w_idx    = r_a[IDX_W+1:2];
   assign w_oor    = (r_a[WIDTH-1:2] >= (WIDTH-2)'(DEPTH));
   assign w_mis    = ((r_size == SZ_HALF) && r_a[0])
                   | ((r_size == SZ_WORD) && (r_a[1:0] != 2'b00))
                   | (r_size == SZ_ILL);
   assign w_fault  = w_mis | w_oor;
   assign w_commit = w_ready && r_we && !w_fault;

   dm_lane_align #(.WIDTH(WIDTH)) u_align (
      .i_size     (r_size),
      .i_a_lo     (r_a[1:0]),
      .i_unsigned (r_uns),
      .i_wd       (r_wd),
      .i_rd_word  (r_ram[w_idx]),
      .o_wmask    (w_wmask),
      .o_wdata    (w_wdata),
      .o_rdata    (w_ld_data)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
      end else if (w_commit) begin
         for (int l = 0; l < NLANES; l++) begin
            if (w_wmask[l]) r_ram[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
         end
      end
   end

   assign bus.Ready        = w_ready;
   assign bus.Busy         = (r_state != IDLE);
   assign bus.Misaligned   = w_ready & w_mis;
   assign bus.Out_Of_Range = w_ready & w_oor;
   assign bus.RD           = (w_ready && !r_we && !w_fault) ? w_ld_data : '0;
   assign bus.Test_Value   = r_ram[TEST_ADDR][TEST_WIDTH-1:0];

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Next-generation data memory for the pipelined MIPS core.
- Byte-addressed, with byte, halfword and word stores and loads; loads can be sign- or zero-extended.
- Has a configurable wait-state count and a Req/Ready handshake, so the MEM stage can stall on Busy.
- Detects misaligned and out-of-range accesses, and exposes a debug test word.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported (4 byte lanes).
- DEPTH, 256, number of 32-bit words.
- WAIT_STATES, 0, extra cycles between request acceptance and response (0..15).
- TEST_WIDTH, 16, width of Test_Value.
- TEST_ADDR, 0, word index mirrored on Test_Value.

Ports:
- CLK  input  1  clock; rising edge.
- RST  input  1  asynchronous, active-high reset.
- Req  input  1  access request; sampled only in IDLE.
- WE  input  1  1 = store, 0 = load; sampled with Req.
- Size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  load zero-extend (1) or sign-extend (0).
- A  input  WIDTH  byte address.
- WD  input  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- RD  output  WIDTH  load data, extended to WIDTH.
- Ready  output  1  one-cycle response strobe.
- Busy  output  1  high while a transaction is outstanding.
- Misaligned  output  1  fault flag, valid with Ready.
- Out_Of_Range  output  1  fault flag, valid with Ready.
- Test_Value  output  TEST_WIDTH  RAM[TEST_ADDR][TEST_WIDTH-1:0], continuous.

Behaviour:
- Reset (RST=1, async):
  - state=IDLE; all RAM words cleared to 0.
  - Ready=0, Busy=0, RD=0, Misaligned=0, Out_Of_Range=0.
  - Any in-flight transaction is dropped with no write.
  - Reset is released synchronously to CLK by the system.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If Req=1 at the rising edge, latch A, WD, WE, Size and Unsigned.
  - Go to WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0; otherwise go to RESP.
  - Req=0 keeps the block in IDLE.
- WAIT: cnt decrements each cycle; when cnt==0, go to RESP.
- RESP:
  - Ready=1 for exactly one cycle, then return to IDLE.
  - Req is ignored during WAIT and RESP.
- Busy = (state != IDLE).
- Latency: Req accepted at edge n gives Ready high in the cycle after edge n+WAIT_STATES.
  - WAIT_STATES=0: Ready is high in the cycle immediately after acceptance.
  - Back-to-back rate: one transaction per WAIT_STATES+2 cycles.
- Faults, computed from the latched request:
  - Word index = A[WIDTH-1:2].
  - Out_Of_Range = (index >= DEPTH).
  - Misaligned = (Size==01 & A[0]) | (Size==10 & A[1:0]!=0) | (Size==11).
  - Both flags are driven only while Ready=1, else 0; both may be set together.
- Store:
  - Commits at the rising edge that ends RESP, only when no fault is set.
  - Lane write mask: byte = 1 lane at A[1:0]; half = lanes {A[1],0}/{A[1],1}; word = all lanes.
  - WD is shifted into the target lanes; untouched lanes keep their value.
  - RD=0 during a store response.
- Load:
  - RD is valid only while Ready=1 and is 0 otherwise, including on any fault.
  - Selected lane(s) are shifted to bit 0, then zero- or sign-extended per Unsigned; word ignores Unsigned.
- Test_Value:
  - Tracks RAM contents continuously.
  - Reflects a store from the edge on which it commits.
- Reset asserted during WAIT or RESP: no write occurs; Ready drops immediately.

Decomposition:
- Shared package (dm_pkg):
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - State enum IDLE/WAIT/RESP.
  - Lane-mask function and WAIT counter width (4 bits).
- One sub-module, dm_lane_align (combinational):
  - Store path: lane mask and shifted write data.
  - Load path: lane extraction and sign/zero extension.
  - The top level holds the FSM, latches and RAM array.

Test Plan:
- Reset, then word store 0xDEADBEEF to A=0x8, then word load A=0x8 with WAIT_STATES=0 -> Ready one cycle after each Req; load RD=0xDEADBEEF; no faults.
- After the previous store, byte store 0x5A to A=0x9, then load A=0x8 -> RD=0xDEAD5AEF. Byte load A=0xB signed -> RD=0xFFFFFFDE; unsigned -> RD=0x000000DE.
- Half store 0x8001 at A=0x6, then half load signed at A=0x6 -> RD=0xFFFF8001; half load at A=0x5 -> Misaligned=1, RD=0; word store at A=0x2 -> Misaligned=1 and memory unchanged.
- DEPTH=256: word store to A=0x400 -> Out_Of_Range=1, no write; load A=0x400 -> RD=0; Size=11 -> Misaligned=1.
- WAIT_STATES=3, Req held high continuously -> Busy high 4 cycles, Ready in 4th cycle after acceptance, next acceptance on the following IDLE edge; Req during Busy ignored.
- Store issued, RST pulsed during WAIT -> Busy=Ready=0 immediately, all RAM=0, Test_Value=0; a store of 0x1234 to A=0x0 afterwards -> Test_Value=0x1234 from the commit edge.
